homa_tx_prio_reg_arb: RTL and testbench
=======================================

HOMA_TX_PRIO_REG_ARB -- requirements
Module: homa_tx_prio_reg_arb

Interface
REQ-001 SHALL provide parameter NUM_MSGS, default 128, number of tx message priority entries (power of two, 2..1024).
REQ-002 SHALL provide parameter PRIO_W, default 8, priority field width.
REQ-003 SHALL provide port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL provide eg_req_valid, input, 1: egress-pipeline request strobe (no backpressure).
REQ-006 SHALL provide eg_req_index, input, 16: tx_msg_id; eg_req_update, input, 1: write when 1; eg_req_prio, input, PRIO_W: write data.
REQ-007 SHALL provide eg_resp_valid, output, 1, and eg_resp_prio, output, PRIO_W: egress response.
REQ-008 SHALL provide ctl_req_valid, input, 1, and ctl_req_ready, output, 1: control-requester handshake.
REQ-009 SHALL provide ctl_req_index, input, 16; ctl_req_update, input, 1; ctl_req_prio, input, PRIO_W.
REQ-010 SHALL provide ctl_resp_valid, output, 1, and ctl_resp_prio, output, PRIO_W: control response.
REQ-011 SHALL provide init_done, output, 1: table clear complete.
REQ-012 SHALL provide eg_drop_cnt, output, 16: egress requests received while init_done=0.

Function
REQ-013 SHALL hold NUM_MSGS x PRIO_W entries in one single-port table; at most one access per cycle.
REQ-014 SHALL use states INIT and RUN; reset enters INIT with clear pointer 0.
REQ-015 In INIT, SHALL write 0 to entry[ptr] each cycle and increment ptr; after writing NUM_MSGS-1, SHALL enter RUN next cycle with init_done=1 (init takes exactly NUM_MSGS cycles).
REQ-016 In INIT, ctl_req_ready SHALL be 0; each egress request SHALL get eg_resp_valid with prio 0 one cycle later, its write discarded, and eg_drop_cnt incremented (saturating at 0xFFFF).
REQ-017 In RUN, egress SHALL have strict priority; ctl_req_ready = !eg_req_valid (combinational).
REQ-018 A control request SHALL be accepted when ctl_req_valid && ctl_req_ready.
REQ-019 An accepted request (egress or control) SHALL produce exactly one response on its own port, 1 cycle later (resp_valid high exactly one cycle).
REQ-020 Read (update=0): response SHALL carry the entry value at the access cycle.
REQ-021 Update (update=1): response SHALL carry the old value; entry SHALL hold new prio from the next cycle on.
REQ-022 Back-to-back accesses to one index SHALL be coherent: an access in cycle N+1 SHALL observe a write done in cycle N.
REQ-023 Index >= NUM_MSGS SHALL give response prio 0 with no table write; only index bits [log2(NUM_MSGS)-1:0] address the table otherwise.
REQ-024 Response prio outputs SHALL be 0 when the matching resp_valid is 0.
REQ-025 Simultaneous eg_req_valid and ctl_req_valid SHALL serve egress only; control request SHALL remain pending (valid/fields held stable by requester until accepted).

Reset
REQ-026 Reset SHALL set eg_resp_valid=0, ctl_resp_valid=0, eg_resp_prio=0, ctl_resp_prio=0, ctl_req_ready=0, init_done=0, eg_drop_cnt=0, state INIT, ptr 0.
REQ-027 Reset asserted mid-RUN or mid-INIT SHALL abort any in-flight response (no resp_valid the following cycle) and restart the full clear.
REQ-028 Table contents before init completes SHALL not be observable on any output.

Verification
REQ-029 Reset, NUM_MSGS=128, idle -> init_done rises exactly 128 cycles after reset deasserts; eg req in cycle 5 -> eg_resp_valid=1, prio 0 at cycle 6, eg_drop_cnt=1.
REQ-030 RUN: eg update idx 3 prio 0x2A, next cycle eg read idx 3 -> responses 0x00 then 0x2A, each one cycle after request.
REQ-031 RUN: ctl_req_valid held with eg_req_valid high 4 cycles -> ctl_req_ready=0 those cycles, ctl accepted cycle 5, ctl_resp_valid cycle 6; no eg response lost.
REQ-032 Eg read idx 200 (>=128) -> prio 0; ctl update idx 200 prio 0x11 then read idx 72 (200 mod 128) -> 0 returned, entry 72 unchanged.
REQ-033 Write idx 7 = 0x55, assert reset one cycle during RUN -> no response after reset, init_done=0 for 128 cycles, then read idx 7 returns 0x00.

Source files
------------

// File: rtl/homa_tx_prio_reg_arb.sv
// rtl/homa_tx_prio_reg_arb.sv - Homa tx message priority table with egress/control arbitration
// Egress has strict priority; the table is cleared after every reset before any access is served.
module homa_tx_prio_reg_arb #(
    parameter int NUM_MSGS = 128,
    parameter int PRIO_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eg_req_valid,
    input  logic [15:0]       eg_req_index,
    input  logic              eg_req_update,
    input  logic [PRIO_W-1:0] eg_req_prio,
    output logic              eg_resp_valid,
    output logic [PRIO_W-1:0] eg_resp_prio,
    input  logic              ctl_req_valid,
    output logic              ctl_req_ready,
    input  logic [15:0]       ctl_req_index,
    input  logic              ctl_req_update,
    input  logic [PRIO_W-1:0] ctl_req_prio,
    output logic              ctl_resp_valid,
    output logic [PRIO_W-1:0] ctl_resp_prio,
    output logic              init_done,
    output logic [15:0]       eg_drop_cnt
);
    localparam int AW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [PRIO_W-1:0] prio_table [NUM_MSGS];

    logic              ctl_acc;
    logic              acc_valid;
    logic [15:0]       acc_index;
    logic              acc_update;
    logic [PRIO_W-1:0] acc_prio;
    logic              in_range;
    logic [AW-1:0]     addr;
    logic [PRIO_W-1:0] rd_val;

    assign ctl_req_ready = (state == RUN) && !eg_req_valid && !reset;
    assign ctl_acc       = ctl_req_valid && ctl_req_ready;
    assign acc_valid     = (state == RUN) && (eg_req_valid || ctl_acc);
    assign acc_index     = eg_req_valid ? eg_req_index  : ctl_req_index;
    assign acc_update    = eg_req_valid ? eg_req_update : ctl_req_update;
    assign acc_prio      = eg_req_valid ? eg_req_prio   : ctl_req_prio;
    assign in_range      = acc_index < 16'(NUM_MSGS);
    assign addr          = acc_index[AW-1:0];
    // Out-of-range indices read as zero rather than aliasing onto a real entry.
    assign rd_val        = in_range ? prio_table[addr] : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                prio_table[ptr] <= '0;
            end else if (acc_valid && acc_update && in_range) begin
                prio_table[addr] <= acc_prio;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= INIT;
            ptr            <= '0;
            init_done      <= 1'b0;
            eg_drop_cnt    <= '0;
            eg_resp_valid  <= 1'b0;
            eg_resp_prio   <= '0;
            ctl_resp_valid <= 1'b0;
            ctl_resp_prio  <= '0;
        end else begin
            eg_resp_valid  <= 1'b0;
            eg_resp_prio   <= '0;
            ctl_resp_valid <= 1'b0;
            ctl_resp_prio  <= '0;
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(NUM_MSGS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                    // Egress cannot be stalled, so it gets a zero answer and is counted as dropped.
                    if (eg_req_valid) begin
                        eg_resp_valid <= 1'b1;
                        if (eg_drop_cnt != 16'hFFFF) begin
                            eg_drop_cnt <= eg_drop_cnt + 16'd1;
                        end
                    end
                end
                RUN: begin
                    if (eg_req_valid) begin
                        eg_resp_valid <= 1'b1;
                        eg_resp_prio  <= rd_val;
                    end else if (ctl_acc) begin
                        ctl_resp_valid <= 1'b1;
                        ctl_resp_prio  <= rd_val;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_homa_tx_prio_reg_arb.sv
// tb/tb_homa_tx_prio_reg_arb.sv - scoreboard bench for homa_tx_prio_reg_arb
module tb_homa_tx_prio_reg_arb;
    localparam int NUM = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        eg_req_valid, eg_req_update, ctl_req_valid, ctl_req_update;
    logic [15:0] eg_req_index, ctl_req_index;
    logic [7:0]  eg_req_prio, ctl_req_prio;
    logic        eg_resp_valid, ctl_resp_valid, ctl_req_ready, init_done;
    logic [7:0]  eg_resp_prio, ctl_resp_prio;
    logic [15:0] eg_drop_cnt;

    homa_tx_prio_reg_arb #(.NUM_MSGS(NUM), .PRIO_W(8)) dut (
        .clock(clk), .reset(reset),
        .eg_req_valid(eg_req_valid), .eg_req_index(eg_req_index),
        .eg_req_update(eg_req_update), .eg_req_prio(eg_req_prio),
        .eg_resp_valid(eg_resp_valid), .eg_resp_prio(eg_resp_prio),
        .ctl_req_valid(ctl_req_valid), .ctl_req_ready(ctl_req_ready),
        .ctl_req_index(ctl_req_index), .ctl_req_update(ctl_req_update),
        .ctl_req_prio(ctl_req_prio),
        .ctl_resp_valid(ctl_resp_valid), .ctl_resp_prio(ctl_resp_prio),
        .init_done(init_done), .eg_drop_cnt(eg_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int due; logic [7:0] prio;} exp_t;
    exp_t eg_q[$];
    exp_t ctl_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          init_cnt = 0;
    logic [15:0] drops = 0;
    logic [7:0]  mdl [NUM];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_access(input int idx, input logic upd, input logic [7:0] p);
        logic [7:0] old;
        old = 8'h00;
        if (idx < NUM) begin
            old = mdl[idx];
            if (upd) mdl[idx] = p;
        end
        return old;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (eg_q.size() > 0 && eg_q[0].due == cyc) begin
                check("eg_resp_valid", eg_resp_valid, 1);
                check("eg_resp_prio", eg_resp_prio, eg_q[0].prio);
                void'(eg_q.pop_front());
            end else begin
                check("eg_idle_valid", eg_resp_valid, 0);
                check("eg_idle_prio", eg_resp_prio, 0);
            end
            if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
                check("ctl_resp_valid", ctl_resp_valid, 1);
                check("ctl_resp_prio", ctl_resp_prio, ctl_q[0].prio);
                void'(ctl_q.pop_front());
            end else begin
                check("ctl_idle_valid", ctl_resp_valid, 0);
                check("ctl_idle_prio", ctl_resp_prio, 0);
            end
        end
    end

    // One clock of stimulus: drive, predict, advance, then check status outputs.
    task automatic step(input logic rst, input logic ev, input int ei, input logic eu,
                        input logic [7:0] ep, input logic cv, input int ci,
                        input logic cu, input logic [7:0] cp);
        logic       in_run;
        logic [7:0] old;
        reset = rst;
        eg_req_valid = ev;  eg_req_index = 16'(ei);  eg_req_update = eu;  eg_req_prio = ep;
        ctl_req_valid = cv; ctl_req_index = 16'(ci); ctl_req_update = cu; ctl_req_prio = cp;
        in_run = (init_cnt >= NUM);
        #1;
        check("ctl_req_ready", ctl_req_ready, in_run && !ev && !rst);
        if (!rst) begin
            if (ev) begin
                if (in_run) begin
                    old = model_access(ei, eu, ep);
                end else begin
                    old = 8'h00;
                    if (drops != 16'hFFFF) drops++;
                end
                eg_q.push_back('{cyc + 1, old});
            end else if (cv && in_run) begin
                old = model_access(ci, cu, cp);
                ctl_q.push_back('{cyc + 1, old});
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            init_cnt = 0;
            drops = 0;
            for (int i = 0; i < NUM; i++) mdl[i] = 8'h00;
        end else if (init_cnt < NUM) begin
            init_cnt++;
        end
        check("init_done", init_done, init_cnt >= NUM);
        check("eg_drop_cnt", eg_drop_cnt, drops);
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    initial begin
        logic       cv_h, cu_h;
        int         ci_h;
        logic [7:0] cp_h;
        logic       ev_r;

        reset = 1'b1;
        eg_req_valid = 0; eg_req_index = 0; eg_req_update = 0; eg_req_prio = 0;
        ctl_req_valid = 0; ctl_req_index = 0; ctl_req_update = 0; ctl_req_prio = 0;
        @(posedge clk);
        #1;
        idle(1);
        idle(1);

        // Clear phase: an egress write and a control request must both be discarded.
        for (int i = 0; i < NUM; i++) begin
            if (i == 5)       step(0, 1, 9, 1, 8'h33, 0, 0, 0, 8'h00);
            else if (i == 10) step(0, 0, 0, 0, 8'h00, 1, 9, 1, 8'h44);
            else              idle(0);
        end

        step(0, 1, 9, 0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 1, 3, 1, 8'h2A, 0, 0, 0, 8'h00);
        step(0, 1, 3, 0, 8'h00, 0, 0, 0, 8'h00);

        // Control held pending behind four egress cycles.
        for (int i = 0; i < 4; i++)
            step(0, 1, 3 + i, i[0], 8'h60 + 8'(i), 1, 5, 1, 8'h77);
        step(0, 0, 0, 0, 8'h00, 1, 5, 1, 8'h77);
        step(0, 0, 0, 0, 8'h00, 1, 5, 0, 8'h00);
        idle(0);

        // Out-of-range index must not alias.
        step(0, 1, 200, 0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 1, 200, 1, 8'h11);
        step(0, 0, 0, 0, 8'h00, 1, 72, 0, 8'h00);
        step(0, 1, 127, 1, 8'hFE, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 1, 127, 0, 8'h00);

        // Random mix on a few hot indices; a refused control request is held stable.
        cv_h = 0; ci_h = 0; cu_h = 0; cp_h = 0;
        for (int i = 0; i < 60; i++) begin
            ev_r = ($urandom_range(0, 2) == 0);
            if (!cv_h) begin
                cv_h = ($urandom_range(0, 1) == 1);
                ci_h = ($urandom_range(0, 7) == 0) ? 130 : int'($urandom_range(0, 3));
                cu_h = $urandom_range(0, 1);
                cp_h = 8'($urandom);
            end
            step(0, ev_r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                 cv_h, ci_h, cu_h, cp_h);
            if (!ev_r) cv_h = 0;
        end

        // Reset during RUN with a request in the same cycle: no response, full clear.
        step(0, 1, 7, 1, 8'h55, 0, 0, 0, 8'h00);
        step(1, 1, 7, 0, 8'h00, 1, 7, 0, 8'h00);
        for (int i = 0; i < NUM; i++) idle(0);
        step(0, 1, 7, 0, 8'h00, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 1, 3, 0, 8'h00);
        idle(0);
        idle(0);
        idle(0);

        check("eg_queue_drained", eg_q.size(), 0);
        check("ctl_queue_drained", ctl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
